nib_pair_arbiter: RTL
=====================

Name: nib_pair_arbiter

Overview:
- Shares one packed nibble-pair register between NUM_REQ nibble-stream requesters.
- Grants one requester at a time, round-robin.
- Collects two consecutive nibbles from the granted requester into a packed {lo, hi} byte and presents it on a valid/ready output with the source id.
- Sits between multiple 4-bit producers and a single byte-wide consumer; aborts stalled pairs by timeout.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- TIMEOUT, 4, max consecutive cycles waiting for the second nibble before abort; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester nibble valid.
- req_nib  input  NUM_REQ*4  per-requester nibble; requester i on bits [4*i+3:4*i].
- req_ready  output  NUM_REQ  per-requester accept; at most one bit set.
- out_valid  output  1  packed byte available.
- out_byte  output  8  pair_t: lo in [7:4], hi in [3:0].
- out_src  output  $clog2(NUM_REQ)  requester that produced out_byte.
- out_ready  input  1  consumer accept.
- abort  output  1  one-cycle pulse: pair discarded on timeout.
- abort_src  output  $clog2(NUM_REQ)  requester aborted; valid only while abort=1.

Behaviour:
- Reset (rst=1 at edge), outputs next cycle:
  - state=IDLE; out_valid, out_byte, out_src, req_ready, abort, abort_src all 0.
  - Timeout counter 0; last-grant pointer = NUM_REQ-1, so the first grant goes to requester 0.
  - Reset mid-operation discards any captured nibble; nothing is emitted.
- State machine:
  - IDLE:
    - Any req_valid set: grant = first set bit searching from pointer+1 with wrap-around; register grant; -> LO.
    - Else stay in IDLE. req_ready all 0.
  - LO:
    - req_ready[grant]=1.
    - On req_valid[grant]: capture nibble as pair.lo; -> HI; counter cleared.
    - No timeout in LO; the grant holds.
  - HI:
    - req_ready[grant]=1.
    - On req_valid[grant]: capture pair.hi; -> OUT.
    - Else counter increments. When it would reach TIMEOUT: abort=1 and abort_src=grant for one cycle, pair discarded, pointer<=grant, -> IDLE.
  - OUT:
    - out_valid=1; out_byte and out_src stable; req_ready all 0.
    - On out_ready: pointer<=grant; -> IDLE.
- Latency and throughput:
  - valid seen in IDLE at cycle 0 with nibbles back-to-back: accept at cycles 1 and 2; out_valid at cycle 3.
  - Peak throughput is one byte per 4 cycles.
- Packing rule:
  - First-declared struct member is the MSB nibble: nibbles 5 then a give out_byte=8'h5a, .lo=4'h5, .hi=4'ha.
- Non-granted requesters:
  - Never see ready; they must hold valid and data.
  - Dropping valid before grant is legal; the arbiter re-evaluates in IDLE only.
- Grant changes only in IDLE; a requester deasserting valid after grant does not release it, except by timeout in HI.
- Simultaneous events:
  - out_ready with out_valid completes the transfer.
  - Timeout and valid in the same cycle: valid wins, no abort.

Decomposition:
- Package nib_pair_pkg:
  - nibble_t (logic [3:0]).
  - pair_t (struct packed {nibble_t lo; nibble_t hi;}).
  - state_t enum {IDLE, LO, HI, OUT}.
- Sub-module nib_rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer. Outputs: grant index, any.
  - Instantiated once.

Test Plan:
- Reset, requester 0 sends 4'h5 then 4'ha back-to-back -> out_valid at cycle 3; out_byte=8'h5a; out_byte.lo=4'h5; out_byte.hi=4'ha; out_src=0.
- Both requesters continuously valid; req0 nibbles 1,2; req1 nibbles 3,4; out_ready=1 -> output sequence 8'h12/src0, 8'h34/src1, 8'h12/src0, strict alternation.
- After OUT reached, out_ready=0 for 5 cycles -> out_valid held 1; out_byte/out_src stable; req_ready=0. out_ready=1 -> next cycle out_valid=0.
- TIMEOUT=4: req1 sends 4'h7 then drops valid; req0 valid throughout -> abort=1 exactly one cycle, 4 cycles after lo capture; abort_src=1; no out_valid for req1; next grant req0.
- rst pulsed while in HI holding lo=4'h9 -> following cycle all outputs 0; no byte 8'h9? emitted; next grant goes to requester 0.
- req1 valid while req0 granted in LO -> req_ready[1]=0 throughout; req1's nibble accepted only after req0's byte is taken.

Source files
------------

// File: rtl/nib_pair_pkg.sv
// Shared types for the nibble-pair arbiter: nibble, packed pair, FSM state.
package nib_pair_pkg;

  typedef logic [3:0] nibble_t;

  // First-declared member lands in the MSBs: lo -> [7:4], hi -> [3:0].
  typedef struct packed {
    nibble_t lo;
    nibble_t hi;
  } pair_t;

  typedef enum logic [1:0] {IDLE, LO, HI, OUT} state_t;

endpackage

// File: rtl/nib_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around, so ptr itself has the lowest priority.
module nib_rr_pick #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      grant,
  output logic               any
);

  logic found;

  // Two passes: indices above ptr first, then the wrapped range 0..ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    any   = |req;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (IW'(j) > ptr)) begin
        found = 1'b1;
        grant = IW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (IW'(j) <= ptr)) begin
        found = 1'b1;
        grant = IW'(j);
      end
    end
  end

endmodule

// File: rtl/nib_pair_arbiter.sv
// Round-robin arbiter that gathers two nibbles from one requester into a
// packed byte, hands it to a single consumer, and aborts stalled pairs.
module nib_pair_arbiter
  import nib_pair_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*4-1:0]       req_nib,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_byte,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  input  logic                       out_ready,
  output logic                       abort,
  output logic [$clog2(NUM_REQ)-1:0] abort_src
);

  localparam int IW = $clog2(NUM_REQ);

  state_t        state, nstate;
  logic [IW-1:0] grant, ptr, pick_gnt;
  logic          pick_any;
  pair_t         pair;
  logic [7:0]    cnt;
  logic          gvld, tmo;
  nibble_t       nib;

  nib_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_gnt),
    .any   (pick_any)
  );

  assign gvld = req_valid[grant];
  assign nib  = req_nib[{grant, 2'b00} +: 4];

  // Next-state, ready and abort decode; valid beats the timeout in HI.
  always_comb begin
    nstate    = state;
    req_ready = '0;
    tmo       = 1'b0;
    case (state)
      IDLE: if (pick_any) nstate = LO;
      LO: begin
        req_ready[grant] = 1'b1;
        if (gvld) nstate = HI;
      end
      HI: begin
        req_ready[grant] = 1'b1;
        if (gvld) nstate = OUT;
        else if (cnt == 8'(TIMEOUT - 1)) begin
          tmo    = 1'b1;
          nstate = IDLE;
        end
      end
      OUT: if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // State, grant, pointer, captured pair and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= IW'(NUM_REQ - 1);
      pair  <= '0;
      cnt   <= '0;
    end else begin
      state <= nstate;
      case (state)
        IDLE: if (pick_any) grant <= pick_gnt;
        LO: if (gvld) begin
          pair.lo <= nib;
          cnt     <= '0;
        end
        HI: begin
          if (gvld) pair.hi <= nib;
          else if (tmo) begin
            ptr  <= grant;
            pair <= '0;
            cnt  <= '0;
          end else cnt <= cnt + 8'd1;
        end
        OUT: if (out_ready) ptr <= grant;
        default: ;
      endcase
    end
  end

  assign out_valid = (state == OUT);
  assign out_byte  = out_valid ? pair : 8'h00;
  assign out_src   = out_valid ? grant : '0;
  assign abort     = tmo;
  assign abort_src = tmo ? grant : '0;

endmodule
